// File: rtl/pc_unit_rs_if.sv
// Control-event and fetch-address bundle between the ex/wb stage (master)
// and the program counter unit (slave).
interface pc_unit_rs_if #(
  parameter int unsigned AW       = 13,
  parameter int unsigned RS_DEPTH = 16
);
  localparam int unsigned CW = $clog2(RS_DEPTH + 1);

  logic          hold_i;
  logic          jump_i;
  logic          call_i;
  logic          ret_i;
  logic [AW-1:0] target_i;
  logic          clr_err_i;
  logic [AW-1:0] pc_o;
  logic          redirect_o;
  logic [CW-1:0] rs_cnt_o;
  logic          rs_ovf_o;
  logic          rs_unf_o;

  modport master (
    output hold_i, jump_i, call_i, ret_i, target_i, clr_err_i,
    input  pc_o, redirect_o, rs_cnt_o, rs_ovf_o, rs_unf_o
  );

  modport slave (
    input  hold_i, jump_i, call_i, ret_i, target_i, clr_err_i,
    output pc_o, redirect_o, rs_cnt_o, rs_ovf_o, rs_unf_o
  );
endinterface

// File: rtl/pc_unit_rs.sv
// Program counter with a local hardware return-address stack.
// CALL/RET are resolved here; overflow/underflow are latched as sticky flags
// and any non-sequential load of the PC raises a one-cycle redirect pulse.
module pc_unit_rs #(
  parameter int unsigned AW        = 13,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned RS_DEPTH  = 16
) (
  input logic         clk,
  input logic         rst_n,
  pc_unit_rs_if.slave bus
);
  localparam int unsigned CW = $clog2(RS_DEPTH + 1);
  localparam int unsigned IW = $clog2(RS_DEPTH);

  logic [AW-1:0] pc_p0;
  logic          redirect_p0;
  logic [CW-1:0] cnt_p0;
  logic          ovf_p0;
  logic          unf_p0;

  logic [AW-1:0] stack [RS_DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;
  logic          redirect_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          push_en;
  logic          ovf_set;
  logic          unf_set;
  logic          full;
  logic          empty;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] top;

  // Stack pointer is the entry count: push writes entry[cnt], pop reads entry[cnt-1].
  assign full   = (cnt_p0 == CW'(RS_DEPTH));
  assign empty  = (cnt_p0 == '0);
  assign wr_idx = IW'(cnt_p0);
  assign rd_idx = IW'(cnt_p0 - CW'(1));
  assign top    = stack[rd_idx];
  assign pc_inc = pc_p0 + AW'(1);

  // Resolve exactly one action per cycle: call > ret > jump > hold > increment.
  always_comb begin
    pc_nxt       = pc_inc;
    redirect_nxt = 1'b0;
    cnt_nxt      = cnt_p0;
    push_en      = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    if (bus.call_i) begin
      pc_nxt       = bus.target_i;
      redirect_nxt = 1'b1;
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        push_en = 1'b1;
        cnt_nxt = cnt_p0 + CW'(1);
      end
    end else if (bus.ret_i) begin
      if (!empty) begin
        pc_nxt       = top;
        cnt_nxt      = cnt_p0 - CW'(1);
        redirect_nxt = 1'b1;
      end else begin
        // An empty-stack return degrades to a no-op that still respects the stall.
        unf_set = 1'b1;
        if (bus.hold_i) pc_nxt = pc_p0;
      end
    end else if (bus.jump_i) begin
      pc_nxt       = bus.target_i;
      redirect_nxt = 1'b1;
    end else if (bus.hold_i) begin
      pc_nxt = pc_p0;
    end
  end

  // PC, stack count and flags; error flags are sticky, a new error beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0       <= AW'(RESET_VEC);
      redirect_p0 <= 1'b0;
      cnt_p0      <= '0;
      ovf_p0      <= 1'b0;
      unf_p0      <= 1'b0;
    end else begin
      pc_p0       <= pc_nxt;
      redirect_p0 <= redirect_nxt;
      cnt_p0      <= cnt_nxt;
      ovf_p0      <= ovf_set | (ovf_p0 & ~bus.clr_err_i);
      unf_p0      <= unf_set | (unf_p0 & ~bus.clr_err_i);
    end
  end

  // Return-address storage; contents are not reset, only the count is.
  always_ff @(posedge clk) begin
    if (rst_n && push_en) stack[wr_idx] <= pc_inc;
  end

  assign bus.pc_o       = pc_p0;
  assign bus.redirect_o = redirect_p0;
  assign bus.rs_cnt_o   = cnt_p0;
  assign bus.rs_ovf_o   = ovf_p0;
  assign bus.rs_unf_o   = unf_p0;
endmodule

// File: tb/tb_pc_unit_rs.sv
// Directed bench for pc_unit_rs with hand-computed expected values.
module tb_pc_unit_rs;
  localparam int unsigned AW       = 13;
  localparam int unsigned RS_DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_unit_rs_if #(.AW(AW), .RS_DEPTH(RS_DEPTH)) bus ();

  pc_unit_rs #(.AW(AW), .RESET_VEC(0), .RS_DEPTH(RS_DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.hold_i    = 1'b0;
    bus.jump_i    = 1'b0;
    bus.call_i    = 1'b0;
    bus.ret_i     = 1'b0;
    bus.clr_err_i = 1'b0;
    bus.target_i  = '0;
  endtask

  function automatic logic [31:0] push_addr(input int j);
    if (j == 0) return 32'h14;
    return 32'h400 + 32'(j - 1) * 32'h10 + 32'h1;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pc", 32'(bus.pc_o), 32'h0);
    chk("rst_redir", 32'(bus.redirect_o), 32'h0);
    chk("rst_cnt", 32'(bus.rs_cnt_o), 32'h0);
    chk("rst_ovf", 32'(bus.rs_ovf_o), 32'h0);
    chk("rst_unf", 32'(bus.rs_unf_o), 32'h0);

    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", 32'(bus.pc_o), 32'(i));
      chk("seq_redir", 32'(bus.redirect_o), 32'h0);
    end

    // Wrap at the top of the address space
    bus.jump_i = 1'b1; bus.target_i = 13'h1FFF;
    tick();
    chk("jmp_pc", 32'(bus.pc_o), 32'h1FFF);
    chk("jmp_redir", 32'(bus.redirect_o), 32'h1);
    idle();
    tick();
    chk("wrap_pc", 32'(bus.pc_o), 32'h0);
    chk("wrap_redir", 32'(bus.redirect_o), 32'h0);

    // Hold, then jump under hold
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", 32'(bus.pc_o), 32'h0);
    end
    bus.jump_i = 1'b1; bus.target_i = 13'h0100;
    tick();
    chk("hjmp_pc", 32'(bus.pc_o), 32'h100);
    chk("hjmp_redir", 32'(bus.redirect_o), 32'h1);
    bus.jump_i = 1'b0;
    tick();
    chk("hjmp_pc2", 32'(bus.pc_o), 32'h100);
    chk("hjmp_redir2", 32'(bus.redirect_o), 32'h0);
    idle();

    // Nested call/ret
    bus.jump_i = 1'b1; bus.target_i = 13'h0010;
    tick();
    chk("nest_start", 32'(bus.pc_o), 32'h10);
    idle();
    bus.call_i = 1'b1; bus.target_i = 13'h0200;
    tick();
    chk("call1_pc", 32'(bus.pc_o), 32'h200);
    chk("call1_cnt", 32'(bus.rs_cnt_o), 32'h1);
    chk("call1_redir", 32'(bus.redirect_o), 32'h1);
    bus.target_i = 13'h0300;
    tick();
    chk("call2_pc", 32'(bus.pc_o), 32'h300);
    chk("call2_cnt", 32'(bus.rs_cnt_o), 32'h2);
    idle();
    bus.ret_i = 1'b1;
    tick();
    chk("ret1_pc", 32'(bus.pc_o), 32'h201);
    chk("ret1_cnt", 32'(bus.rs_cnt_o), 32'h1);
    chk("ret1_redir", 32'(bus.redirect_o), 32'h1);
    tick();
    chk("ret2_pc", 32'(bus.pc_o), 32'h11);
    chk("ret2_cnt", 32'(bus.rs_cnt_o), 32'h0);
    idle();

    // Back-to-back call, ret, call, ret
    bus.call_i = 1'b1; bus.target_i = 13'h0040;
    tick();
    chk("bb_call1", 32'(bus.pc_o), 32'h40);
    idle(); bus.ret_i = 1'b1;
    tick();
    chk("bb_ret1", 32'(bus.pc_o), 32'h12);
    idle(); bus.call_i = 1'b1; bus.target_i = 13'h0050;
    tick();
    chk("bb_call2", 32'(bus.pc_o), 32'h50);
    chk("bb_call2_cnt", 32'(bus.rs_cnt_o), 32'h1);
    idle(); bus.ret_i = 1'b1;
    tick();
    chk("bb_ret2", 32'(bus.pc_o), 32'h13);
    chk("bb_ret2_cnt", 32'(bus.rs_cnt_o), 32'h0);
    idle();

    // Overflow: RS_DEPTH+1 calls from pc 0x13
    for (int i = 0; i <= int'(RS_DEPTH); i++) begin
      bus.call_i = 1'b1;
      bus.target_i = 13'(32'h400 + 32'(i) * 32'h10);
      tick();
      chk("ovf_call_pc", 32'(bus.pc_o), 32'h400 + 32'(i) * 32'h10);
    end
    chk("ovf_cnt", 32'(bus.rs_cnt_o), 32'(RS_DEPTH));
    chk("ovf_flag", 32'(bus.rs_ovf_o), 32'h1);
    idle();
    bus.ret_i = 1'b1;
    for (int k = 0; k < int'(RS_DEPTH); k++) begin
      tick();
      chk("ovf_ret_pc", 32'(bus.pc_o), push_addr(int'(RS_DEPTH) - 1 - k));
    end
    chk("ovf_ret_cnt", 32'(bus.rs_cnt_o), 32'h0);
    chk("ovf_sticky", 32'(bus.rs_ovf_o), 32'h1);

    // Underflow: pc is 0x14, stack empty
    tick();
    chk("unf_pc", 32'(bus.pc_o), 32'h15);
    chk("unf_flag", 32'(bus.rs_unf_o), 32'h1);
    chk("unf_redir", 32'(bus.redirect_o), 32'h0);
    chk("unf_cnt", 32'(bus.rs_cnt_o), 32'h0);
    bus.hold_i = 1'b1;
    tick();
    chk("unf_hold_pc", 32'(bus.pc_o), 32'h15);
    idle(); bus.clr_err_i = 1'b1;
    tick();
    chk("clr_ovf", 32'(bus.rs_ovf_o), 32'h0);
    chk("clr_unf", 32'(bus.rs_unf_o), 32'h0);
    chk("clr_pc", 32'(bus.pc_o), 32'h16);
    bus.ret_i = 1'b1;
    tick();
    chk("clr_set_wins", 32'(bus.rs_unf_o), 32'h1);
    chk("clr_set_pc", 32'(bus.pc_o), 32'h17);
    bus.ret_i = 1'b0;
    tick();
    chk("clr_again", 32'(bus.rs_unf_o), 32'h0);
    idle();

    // call and ret together: call only
    bus.call_i = 1'b1; bus.ret_i = 1'b1; bus.target_i = 13'h0600;
    tick();
    chk("cr_pc", 32'(bus.pc_o), 32'h600);
    chk("cr_cnt", 32'(bus.rs_cnt_o), 32'h1);
    chk("cr_unf", 32'(bus.rs_unf_o), 32'h0);
    bus.ret_i = 1'b0; bus.target_i = 13'h0700;
    tick();
    bus.target_i = 13'h0710;
    tick();
    chk("pre_rst_cnt", 32'(bus.rs_cnt_o), 32'h3);

    // Reset mid-stream with a call pending
    bus.target_i = 13'h0720;
    rst_n = 1'b0;
    tick();
    chk("mrst_pc", 32'(bus.pc_o), 32'h0);
    chk("mrst_cnt", 32'(bus.rs_cnt_o), 32'h0);
    chk("mrst_redir", 32'(bus.redirect_o), 32'h0);
    rst_n = 1'b1;
    idle(); bus.ret_i = 1'b1;
    tick();
    chk("mrst_unf", 32'(bus.rs_unf_o), 32'h1);
    chk("mrst_unf_pc", 32'(bus.pc_o), 32'h1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
